// File: rtl/axi_line_master_if.sv
// axi_line_master_if: AXI4 bus between the line master and its responder
interface axi_line_master_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5
);
  logic                   axi_aw_valid;
  logic                   axi_aw_ready;
  logic [ADDR_BITS-1:0]   axi_aw_bits_addr;
  logic [7:0]             axi_aw_bits_len;
  logic [2:0]             axi_aw_bits_size;
  logic [1:0]             axi_aw_bits_burst;
  logic [ID_BITS-1:0]     axi_aw_bits_id;
  logic                   axi_aw_bits_lock;
  logic [3:0]             axi_aw_bits_cache;
  logic [2:0]             axi_aw_bits_prot;
  logic [3:0]             axi_aw_bits_qos;
  logic                   axi_w_valid;
  logic                   axi_w_ready;
  logic [DATA_BITS-1:0]   axi_w_bits_data;
  logic [DATA_BITS/8-1:0] axi_w_bits_strb;
  logic                   axi_w_bits_last;
  logic                   axi_b_valid;
  logic                   axi_b_ready;
  logic [1:0]             axi_b_bits_resp;
  logic [ID_BITS-1:0]     axi_b_bits_id;
  logic                   axi_ar_valid;
  logic                   axi_ar_ready;
  logic [ADDR_BITS-1:0]   axi_ar_bits_addr;
  logic [7:0]             axi_ar_bits_len;
  logic [2:0]             axi_ar_bits_size;
  logic [1:0]             axi_ar_bits_burst;
  logic [ID_BITS-1:0]     axi_ar_bits_id;
  logic                   axi_ar_bits_lock;
  logic [3:0]             axi_ar_bits_cache;
  logic [2:0]             axi_ar_bits_prot;
  logic [3:0]             axi_ar_bits_qos;
  logic                   axi_r_valid;
  logic                   axi_r_ready;
  logic [DATA_BITS-1:0]   axi_r_bits_data;
  logic [1:0]             axi_r_bits_resp;
  logic                   axi_r_bits_last;
  logic [ID_BITS-1:0]     axi_r_bits_id;
  modport master (
    output axi_aw_valid, axi_aw_bits_addr, axi_aw_bits_len, axi_aw_bits_size, axi_aw_bits_burst,
           axi_aw_bits_id, axi_aw_bits_lock, axi_aw_bits_cache, axi_aw_bits_prot, axi_aw_bits_qos,
           axi_w_valid, axi_w_bits_data, axi_w_bits_strb, axi_w_bits_last, axi_b_ready,
           axi_ar_valid, axi_ar_bits_addr, axi_ar_bits_len, axi_ar_bits_size, axi_ar_bits_burst,
           axi_ar_bits_id, axi_ar_bits_lock, axi_ar_bits_cache, axi_ar_bits_prot, axi_ar_bits_qos,
           axi_r_ready,
    input  axi_aw_ready, axi_w_ready, axi_b_valid, axi_b_bits_resp, axi_b_bits_id,
           axi_ar_ready, axi_r_valid, axi_r_bits_data, axi_r_bits_resp, axi_r_bits_last, axi_r_bits_id
  );
  modport slave (
    input  axi_aw_valid, axi_aw_bits_addr, axi_aw_bits_len, axi_aw_bits_size, axi_aw_bits_burst,
           axi_aw_bits_id, axi_aw_bits_lock, axi_aw_bits_cache, axi_aw_bits_prot, axi_aw_bits_qos,
           axi_w_valid, axi_w_bits_data, axi_w_bits_strb, axi_w_bits_last, axi_b_ready,
           axi_ar_valid, axi_ar_bits_addr, axi_ar_bits_len, axi_ar_bits_size, axi_ar_bits_burst,
           axi_ar_bits_id, axi_ar_bits_lock, axi_ar_bits_cache, axi_ar_bits_prot, axi_ar_bits_qos,
           axi_r_ready,
    output axi_aw_ready, axi_w_ready, axi_b_valid, axi_b_bits_resp, axi_b_bits_id,
           axi_ar_ready, axi_r_valid, axi_r_bits_data, axi_r_bits_resp, axi_r_bits_last, axi_r_bits_id
  );
endinterface

// File: rtl/axi_line_master.sv
// axi_line_master: one-line-per-command AXI4 initiator, streaming client data through to/from AXI
module axi_line_master #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5,
  parameter int LINE_SIZE = 64,
  parameter int TXN_ID    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_last,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [1:0]           rsp_err,
  axi_line_master_if.master    axi
);
  localparam int BEATS = LINE_SIZE / (DATA_BITS / 8);
  localparam logic [7:0] LAST = 8'(BEATS - 1);
  localparam logic [2:0] SIZE = 3'($clog2(DATA_BITS / 8));
  localparam logic [ID_BITS-1:0] ID = ID_BITS'(TXN_ID);
  localparam logic [ADDR_BITS-1:0] MASK = ~ADDR_BITS'(LINE_SIZE - 1);
  typedef enum logic [2:0] {IDLE, AR, RD, AW, WR, B, RSP} state_t;
  state_t state, state_n;
  logic [ADDR_BITS-1:0] addr;
  logic                 write;
  logic [1:0]           err;
  logic [7:0]           cnt;
  logic                 last_beat;
  logic                 w_hs, b_hs, r_hs;
  logic [1:0]           b_err, r_err;
  assign last_beat = cnt == LAST;
  assign w_hs = state == WR && wr_valid && axi.axi_w_ready;
  assign b_hs = state == B && axi.axi_b_valid;
  assign r_hs = state == RD && axi.axi_r_valid && rd_ready;
  assign b_err = axi.axi_b_bits_id != ID ? 2'b10 : (axi.axi_b_bits_resp > err ? axi.axi_b_bits_resp : err);
  // a last flag out of step with our own count, or a foreign id, is a protocol error
  assign r_err = (axi.axi_r_bits_last != last_beat || axi.axi_r_bits_id != ID) ? 2'b10 :
                 (axi.axi_r_bits_resp > err ? axi.axi_r_bits_resp : err);
  assign axi.axi_aw_bits_addr  = addr;
  assign axi.axi_aw_bits_len   = LAST;
  assign axi.axi_aw_bits_size  = SIZE;
  assign axi.axi_aw_bits_burst = 2'b01;
  assign axi.axi_aw_bits_id    = ID;
  assign axi.axi_aw_bits_lock  = 1'b0;
  assign axi.axi_aw_bits_cache = 4'd0;
  assign axi.axi_aw_bits_prot  = 3'd0;
  assign axi.axi_aw_bits_qos   = 4'd0;
  assign axi.axi_ar_bits_addr  = addr;
  assign axi.axi_ar_bits_len   = LAST;
  assign axi.axi_ar_bits_size  = SIZE;
  assign axi.axi_ar_bits_burst = 2'b01;
  assign axi.axi_ar_bits_id    = ID;
  assign axi.axi_ar_bits_lock  = 1'b0;
  assign axi.axi_ar_bits_cache = 4'd0;
  assign axi.axi_ar_bits_prot  = 3'd0;
  assign axi.axi_ar_bits_qos   = 4'd0;
  assign axi.axi_w_bits_data   = wr_data;
  assign axi.axi_w_bits_strb   = '1;
  assign axi.axi_w_bits_last   = last_beat;
  assign rd_data   = axi.axi_r_bits_data;
  assign rd_last   = last_beat;
  assign rsp_write = write;
  assign rsp_err   = err;
  always_comb begin
    state_n = state;
    cmd_ready = 1'b0;
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    rsp_valid = 1'b0;
    axi.axi_aw_valid = 1'b0;
    axi.axi_ar_valid = 1'b0;
    axi.axi_w_valid = 1'b0;
    axi.axi_b_ready = 1'b0;
    axi.axi_r_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) state_n = cmd_write ? AW : AR;
      end
      AW: begin
        axi.axi_aw_valid = 1'b1;
        if (axi.axi_aw_ready) state_n = WR;
      end
      AR: begin
        axi.axi_ar_valid = 1'b1;
        if (axi.axi_ar_ready) state_n = RD;
      end
      WR: begin
        axi.axi_w_valid = wr_valid;
        wr_ready = axi.axi_w_ready;
        if (w_hs && last_beat) state_n = B;
      end
      B: begin
        axi.axi_b_ready = 1'b1;
        if (b_hs) state_n = RSP;
      end
      RD: begin
        rd_valid = axi.axi_r_valid;
        axi.axi_r_ready = rd_ready;
        if (r_hs && last_beat) state_n = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= '0;
      write <= 1'b0;
      err <= 2'b00;
      cnt <= 8'd0;
    end else if (state == IDLE && cmd_valid) begin
      addr <= cmd_addr & MASK;
      write <= cmd_write;
      err <= 2'b00;
      cnt <= 8'd0;
    end else if (w_hs) begin
      cnt <= cnt + 8'd1;
    end else if (b_hs) begin
      err <= b_err;
    end else if (r_hs) begin
      cnt <= cnt + 8'd1;
      err <= r_err;
    end
  end
endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master: table-driven line transfers against a small AXI memory responder
module tb_axi_line_master;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [63:0] wr_data = '0;
  logic        rd_valid, rd_ready = 1'b0, rd_last;
  logic [63:0] rd_data;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [1:0]  rsp_err;
  int total = 0, bad = 0;
  axi_line_master_if axi ();
  axi_line_master dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .axi(axi)
  );
  always #5 clock = ~clock;
  int          stall_cyc = 0;
  bit          rand_mode = 0;
  logic [5:0]  err_beat = 6'd63, last_at = 6'd7;
  logic [1:0]  err_resp = 2'd0, b_resp = 2'd0;
  logic [4:0]  b_id = 5'd0;
  logic [63:0] mem [0:63];
  logic [31:0] cap_aw_addr, cap_ar_addr;
  logic [29:0] cap_aw_attr, cap_ar_attr;
  int          wbeats = 0, bcount = 0, wlast_bad = 0, unstable_cnt = 0, aw_wait = 0, ar_wait = 0;
  logic [5:0]  wbase, wbeat, rbase, rbeat;
  logic        pend_aw, pend_ar;
  logic [31:0] held_aw, held_ar;
  assign axi.axi_r_bits_data = mem[6'(rbase + rbeat)];
  assign axi.axi_r_bits_resp = rbeat == err_beat ? err_resp : 2'd0;
  assign axi.axi_r_bits_last = rbeat == last_at;
  assign axi.axi_r_bits_id   = 5'd0;
  always @(posedge clock) begin
    if (reset) begin
      axi.axi_aw_ready <= 0; axi.axi_ar_ready <= 0; axi.axi_w_ready <= 0;
      axi.axi_b_valid <= 0; axi.axi_r_valid <= 0;
      aw_wait <= 0; ar_wait <= 0; wbeat <= 0; rbeat <= 0; wbase <= 0; rbase <= 0;
      pend_aw <= 0; pend_ar <= 0;
    end else begin
      if (pend_aw && (!axi.axi_aw_valid || axi.axi_aw_bits_addr != held_aw)) unstable_cnt <= unstable_cnt + 1;
      if (pend_ar && (!axi.axi_ar_valid || axi.axi_ar_bits_addr != held_ar)) unstable_cnt <= unstable_cnt + 1;
      pend_aw <= axi.axi_aw_valid && !axi.axi_aw_ready;
      pend_ar <= axi.axi_ar_valid && !axi.axi_ar_ready;
      held_aw <= axi.axi_aw_bits_addr;
      held_ar <= axi.axi_ar_bits_addr;
      if (axi.axi_aw_valid && axi.axi_aw_ready) begin
        axi.axi_aw_ready <= 0; aw_wait <= 0;
        cap_aw_addr <= axi.axi_aw_bits_addr;
        cap_aw_attr <= {axi.axi_aw_bits_len, axi.axi_aw_bits_size, axi.axi_aw_bits_burst, axi.axi_aw_bits_id,
                        axi.axi_aw_bits_lock, axi.axi_aw_bits_cache, axi.axi_aw_bits_prot, axi.axi_aw_bits_qos};
        wbase <= axi.axi_aw_bits_addr[8:3]; wbeat <= 0;
      end else if (axi.axi_aw_valid) begin
        aw_wait <= aw_wait + 1; axi.axi_aw_ready <= aw_wait >= stall_cyc;
      end
      axi.axi_w_ready <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.axi_w_valid && axi.axi_w_ready) begin
        mem[6'(wbase + wbeat)] <= axi.axi_w_bits_data;
        if (axi.axi_w_bits_last != (wbeat == 6'd7) || axi.axi_w_bits_strb != 8'hff) wlast_bad <= wlast_bad + 1;
        wbeat <= wbeat + 1; wbeats <= wbeats + 1;
        if (wbeat == 6'd7) begin axi.axi_b_valid <= 1; axi.axi_b_bits_resp <= b_resp; axi.axi_b_bits_id <= b_id; end
      end
      if (axi.axi_b_valid && axi.axi_b_ready) begin axi.axi_b_valid <= 0; bcount <= bcount + 1; end
      if (axi.axi_ar_valid && axi.axi_ar_ready) begin
        axi.axi_ar_ready <= 0; ar_wait <= 0;
        cap_ar_addr <= axi.axi_ar_bits_addr;
        cap_ar_attr <= {axi.axi_ar_bits_len, axi.axi_ar_bits_size, axi.axi_ar_bits_burst, axi.axi_ar_bits_id,
                        axi.axi_ar_bits_lock, axi.axi_ar_bits_cache, axi.axi_ar_bits_prot, axi.axi_ar_bits_qos};
        rbase <= axi.axi_ar_bits_addr[8:3]; rbeat <= 0; axi.axi_r_valid <= 1;
      end else if (axi.axi_ar_valid) begin
        ar_wait <= ar_wait + 1; axi.axi_ar_ready <= ar_wait >= stall_cyc;
      end
      if (axi.axi_r_valid && axi.axi_r_ready) begin
        if (rbeat == 6'd7) axi.axi_r_valid <= 0;
        else rbeat <= rbeat + 1;
      end
    end
  end
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    logic [63:0] base;
    bit          stall;
    logic [5:0]  err_beat;
    logic [1:0]  err_resp;
    logic [5:0]  last_at;
    logic [1:0]  b_resp;
    logic [4:0]  b_id;
    logic [1:0]  exp_err;
  } vec_t;
  vec_t vt [10];
  localparam logic [29:0] ATTR = {8'd7, 3'd3, 2'd1, 5'd0, 1'b0, 4'd0, 3'd0, 4'd0};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input string nm, input vec_t v);
    int n;
    bit hs;
    int wb0, bc0, wl0, us0;
    wb0 = wbeats; bc0 = bcount; wl0 = wlast_bad; us0 = unstable_cnt;
    @(negedge clock);
    stall_cyc = v.stall ? 5 : 0; rand_mode = v.stall; err_beat = v.err_beat; err_resp = v.err_resp;
    last_at = v.last_at; b_resp = v.b_resp; b_id = v.b_id;
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr;
    hs = 0;
    for (int c = 0; c < 100 && !hs; c++) begin #1 hs = cmd_ready; @(negedge clock); end
    cmd_valid = 0;
    chk({nm, "/cmd_accept"}, 64'(hs), 64'd1);
    n = 0;
    for (int c = 0; c < 2000 && n < 8; c++) begin
      if (v.wr) begin
        wr_valid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_data = v.base + 64'(n);
        #1 hs = wr_valid && wr_ready;
      end else begin
        rd_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        #1 hs = rd_valid && rd_ready;
        if (hs) begin
          chk($sformatf("%s/rd_data%0d", nm, n), rd_data, v.base + 64'(n));
          chk($sformatf("%s/rd_last%0d", nm, n), 64'(rd_last), 64'(n == 7));
        end
      end
      @(negedge clock);
      if (hs) n++;
    end
    wr_valid = 0; rd_ready = 0;
    chk({nm, "/beats"}, 64'(n), 64'd8);
    hs = 0;
    for (int c = 0; c < 200 && !hs; c++) begin #1 hs = rsp_valid; if (!hs) @(negedge clock); end
    chk({nm, "/rsp_seen"}, 64'(hs), 64'd1);
    if (v.stall) begin
      repeat (3) @(negedge clock);
      #1 chk({nm, "/rsp_hold"}, 64'({rsp_valid, rsp_write, rsp_err}), 64'({1'b1, v.wr, v.exp_err}));
    end
    rsp_ready = 1;
    #1 chk({nm, "/rsp_write"}, 64'(rsp_write), 64'(v.wr));
    chk({nm, "/rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    @(negedge clock);
    rsp_ready = 0;
    #1 chk({nm, "/back_idle"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    chk({nm, "/addr_stable"}, 64'(unstable_cnt - us0), 64'd0);
    if (v.wr) begin
      chk({nm, "/aw_addr"}, 64'(cap_aw_addr), 64'(v.exp_addr));
      chk({nm, "/aw_attr"}, 64'(cap_aw_attr), 64'(ATTR));
      chk({nm, "/w_beats"}, 64'(wbeats - wb0), 64'd8);
      chk({nm, "/w_last"}, 64'(wlast_bad - wl0), 64'd0);
      chk({nm, "/b_count"}, 64'(bcount - bc0), 64'd1);
      for (int k = 0; k < 8; k++)
        chk($sformatf("%s/mem%0d", nm, k), mem[6'(v.exp_addr[8:3] + 6'(k))], v.base + 64'(k));
    end else begin
      chk({nm, "/ar_addr"}, 64'(cap_ar_addr), 64'(v.exp_addr));
      chk({nm, "/ar_attr"}, 64'(cap_ar_attr), 64'(ATTR));
    end
  endtask
  initial begin
    bit hs;
    int n;
    vt[0] = '{1, 32'h80000040, 32'h80000040, 64'h1000, 0, 6'd63, 2'd0, 6'd7, 2'd0, 5'd0, 2'd0};
    vt[1] = '{0, 32'h80000040, 32'h80000040, 64'h1000, 0, 6'd63, 2'd0, 6'd7, 2'd0, 5'd0, 2'd0};
    vt[2] = '{0, 32'h80000047, 32'h80000040, 64'h1000, 0, 6'd63, 2'd0, 6'd7, 2'd0, 5'd0, 2'd0};
    vt[3] = '{1, 32'h80000087, 32'h80000080, 64'h2000, 1, 6'd63, 2'd0, 6'd7, 2'd0, 5'd0, 2'd0};
    vt[4] = '{0, 32'h80000080, 32'h80000080, 64'h2000, 1, 6'd63, 2'd0, 6'd7, 2'd0, 5'd0, 2'd0};
    vt[5] = '{0, 32'h80000040, 32'h80000040, 64'h1000, 0, 6'd2,  2'd2, 6'd7, 2'd0, 5'd0, 2'd2};
    vt[6] = '{0, 32'h80000040, 32'h80000040, 64'h1000, 0, 6'd63, 2'd0, 6'd5, 2'd0, 5'd0, 2'd2};
    vt[7] = '{1, 32'h800000c0, 32'h800000c0, 64'h3000, 0, 6'd63, 2'd0, 6'd7, 2'd1, 5'd0, 2'd1};
    vt[8] = '{1, 32'h800000c0, 32'h800000c0, 64'h3000, 0, 6'd63, 2'd0, 6'd7, 2'd0, 5'd3, 2'd2};
    vt[9] = '{0, 32'h800000c0, 32'h800000c0, 64'h3000, 0, 6'd7,  2'd3, 6'd7, 2'd0, 5'd0, 2'd3};
    repeat (2) @(negedge clock);
    #1 chk("reset/cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset/valids", 64'({axi.axi_aw_valid, axi.axi_ar_valid, axi.axi_w_valid, rd_valid, rsp_valid,
                             wr_ready, axi.axi_b_ready, axi.axi_r_ready}), 64'd0);
    reset = 0;
    #1 chk("reset/cmd_ready_after", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vt[i]);
    @(negedge clock);
    stall_cyc = 0; rand_mode = 0; err_beat = 6'd63; last_at = 6'd7; b_resp = 0; b_id = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h80000100;
    hs = 0;
    for (int c = 0; c < 100 && !hs; c++) begin #1 hs = cmd_ready; @(negedge clock); end
    cmd_valid = 0;
    chk("rst_mid/cmd_accept", 64'(hs), 64'd1);
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      wr_valid = 1; wr_data = 64'h4000 + 64'(n);
      #1 hs = wr_valid && wr_ready;
      @(negedge clock);
      if (hs) n++;
    end
    chk("rst_mid/beats_before", 64'(n), 64'd3);
    wr_data = 64'h4003;
    reset = 1;
    #1 chk("rst_mid/cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
    @(negedge clock);
    #1 chk("rst_mid/valids", 64'({axi.axi_aw_valid, axi.axi_ar_valid, axi.axi_w_valid, rd_valid, rsp_valid,
                                   wr_ready, axi.axi_b_ready, axi.axi_r_ready}), 64'd0);
    reset = 0; wr_valid = 0;
    #1 chk("rst_mid/cmd_ready_after", 64'(cmd_ready), 64'd1);
    run_vec("post_reset_wr", '{1, 32'h80000100, 32'h80000100, 64'h5000, 0, 6'd63, 2'd0, 6'd7, 2'd0, 5'd0, 2'd0});
    run_vec("post_reset_rd", '{0, 32'h80000100, 32'h80000100, 64'h5000, 1, 6'd63, 2'd0, 6'd7, 2'd0, 5'd0, 2'd0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- AXI4 initiator that moves one cache line per command between a simple client interface and an AXI4 responder, e.g. the simulated DRAM model or the chip memory port.
- Handles one transaction at a time: line read (AR/R) or line write (AW/W/B).
- Write data is streamed in from the client; read data is streamed out to the client.
- Returns one completion response per command.

Parameters:
- ADDR_BITS, 32, AXI and command address width.
- DATA_BITS, 64, AXI data width; only 64 is supported.
- ID_BITS, 5, AXI ID width.
- LINE_SIZE, 64, line size in bytes; BEATS = LINE_SIZE/(DATA_BITS/8) = 8.
- TXN_ID, 0, constant ID driven on AR and AW.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1 = line write, 0 = line read.
- cmd_addr  in  ADDR_BITS  line address; low log2(LINE_SIZE) bits ignored.
- wr_valid/wr_ready  in/out  1/1  write-data beat handshake.
- wr_data  in  DATA_BITS  write beat, lowest address first.
- rd_valid/rd_ready  out/in  1/1  read-data beat handshake.
- rd_data  out  DATA_BITS  read beat.
- rd_last  out  1  final read beat.
- rsp_valid/rsp_ready  out/in  1/1  completion handshake.
- rsp_write  out  1  echoes cmd_write.
- rsp_err  out  2  worst AXI resp seen; protocol error forces 2'b10.
- axi_aw_valid/axi_aw_ready  out/in  1/1.
- axi_aw_bits_addr  out  ADDR_BITS.
- axi_aw_bits_len/size/burst/id  out  8/3/2/ID_BITS  = BEATS-1, log2(DATA_BITS/8), 2'b01, TXN_ID.
- axi_aw_bits_lock/cache/prot/qos  out  1/4/3/4  constant 0.
- axi_w_valid/axi_w_ready  out/in  1/1.
- axi_w_bits_data  out  DATA_BITS.
- axi_w_bits_strb  out  DATA_BITS/8  all ones.
- axi_w_bits_last  out  1.
- axi_b_valid/axi_b_ready  in/out  1/1.
- axi_b_bits_resp/id  in  2/ID_BITS.
- axi_ar_*  out  same set and constants as axi_aw_*.
- axi_r_valid/axi_r_ready  in/out  1/1.
- axi_r_bits_data/resp/last/id  in  DATA_BITS/2/1/ID_BITS.

Behaviour:
- States: IDLE, AR, RD, AW, WR, B, RSP.
- Reset: state IDLE; every AXI valid, rd_valid, rsp_valid, wr_ready, axi_b_ready and axi_r_ready = 0; cmd_ready = 0 while reset is high; err accumulator = 0; beat counter = 0.
- Reset mid-transaction: the transaction is abandoned, with no completion. The responder must be reset together with this block.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register the aligned address and cmd_write, clear err and counter, then go to AW (write) or AR (read).
- AR/AW:
  - Registered valid is asserted the cycle after entry.
  - Address and all attributes are held stable until ready.
  - On handshake go to RD or WR.
  - A command accepted in cycle N gives address valid in cycle N+1.
- WR:
  - axi_w_valid = wr_valid; wr_ready = axi_w_ready; data passes straight through.
  - axi_w_bits_last = (count == BEATS-1).
  - Count increments per beat; after the last beat go to B.
  - The client may stall arbitrarily; no beat may be lost or duplicated.
- B:
  - axi_b_ready = 1.
  - On axi_b_valid, err = max(err, resp); if b id != TXN_ID, err = 2'b10.
  - Then go to RSP.
- RD:
  - rd_valid = axi_r_valid; axi_r_ready = rd_ready; rd_data and rd_last pass through.
  - Each beat: err = max(err, resp).
  - If r_last disagrees with (count == BEATS-1), or r id != TXN_ID, err = 2'b10.
  - After the beat where count == BEATS-1, go to RSP. rd_last presented to the client is (count == BEATS-1), not the raw r_last.
- RSP:
  - rsp_valid = 1, held with rsp_write/rsp_err stable until rsp_ready, then IDLE.
  - A new command is accepted no earlier than the cycle after the rsp handshake.
- Counter width is 8 bits; BEATS ≤ 256 is required.
- One transaction at a time; no overlapping AW and W.

Test Plan:
- Write 0x80000040, beats 0x1000+i (i=0..7), zero-wait responder -> AW addr 0x80000040, len 7, size 3, burst 1; w_last only on beat 7; one B; rsp_write=1, rsp_err=0.
- Read 0x80000040 after that write -> AR len 7; rd_data = 0x1000..0x1007 in order; rd_last on the 8th beat only; rsp_err=0.
- cmd_addr=0x80000047 -> axi_ar_bits_addr=0x80000040.
- Toggle rd_ready/wr_valid pseudo-randomly, and have the responder hold ready low for 5 cycles -> address stable while valid; exactly 8 beats each way; data intact.
- Responder returns resp=2 on read beat 2, or r_last early on beat 5 -> rsp_err=2'b10; no hang.
- Assert reset during WR beat 3 -> next cycle all valids 0; cmd_ready=1 the cycle after reset drops; a subsequent full write completes normally.
